// File: rtl/program_loader.sv
// ---------------------------------------------------------------------------
// program_loader
//
// Boot-time loader sitting in front of the MIPS core's program memory. It
// receives a byte stream made of a 16-bit little-endian word count N, then
// 4*N payload bytes, then one checksum byte. Payload bytes are packed
// little-endian into 32-bit words and written sequentially from byte
// address 0. The checksum byte must equal the XOR of every byte that came
// before it (both length bytes and all payload bytes). The processor is held
// in reset until an image has been loaded and verified.
//
// Ports:
//   clk           rising-edge clock
//   reset         synchronous, active-high reset
//   start         one-cycle load request (honoured in IDLE or ERROR only)
//   byte_valid    byte_data carries a byte
//   byte_data     stream byte
//   byte_ready    loader accepts a byte this cycle
//   mem_we        program memory write strobe (one cycle per word)
//   mem_addr      byte address of the word being written
//   mem_wdata     word being written
//   words_loaded  words written during the current load
//   cpu_reset     processor reset hold; low only after a verified load
//   done          load finished with matching checksum
//   error         load aborted (bad length or bad checksum)
//   dbgState      current FSM state, for observation only
//
// Handshake: a byte transfers on a rising edge where byte_valid and
// byte_ready are both 1. byte_ready is a pure decode of the state register
// (LEN_LO, LEN_HI, DATA, CHECK) and never depends on byte_valid; a byte
// offered while byte_ready is 0 is simply ignored.
// ---------------------------------------------------------------------------
module program_loader #(
   parameter int MEMORY_DEPTH = 300,
   parameter int DATA_WIDTH   = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  byte_valid,
   input  logic [7:0]            byte_data,
   output logic                  byte_ready,
   output logic                  mem_we,
   output logic [31:0]           mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   output logic [15:0]           words_loaded,
   output logic                  cpu_reset,
   output logic                  done,
   output logic                  error,
   output logic [2:0]            dbgState
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LEN_LO = 3'd1,
      LEN_HI = 3'd2,
      DATA   = 3'd3,
      CHECK  = 3'd4,
      DONE   = 3'd5,
      ERROR  = 3'd6
   } loaderState_t;

   loaderState_t state;
   loaderState_t nextState;

   logic [15:0]           lenReg;     // word count N from the header
   logic [7:0]            csum;       // running XOR of accepted bytes
   logic [1:0]            lane;       // next byte position within the word
   logic [DATA_WIDTH-9:0] wordBuf;    // lanes 0..2 of the word in progress

   logic        accept;
   logic        startOk;
   logic [15:0] newLen;
   logic        lenBad;
   logic [15:0] wordsNext;

   assign accept    = byte_valid & byte_ready;
   assign startOk   = start & ((state == IDLE) | (state == ERROR));
   assign newLen    = {byte_data, lenReg[7:0]};
   assign lenBad    = (newLen == 16'd0) || ({16'd0, newLen} > 32'(MEMORY_DEPTH));
   assign wordsNext = words_loaded + 16'd1;

   // Status flags are decoded from the state register, so they change on the
   // same edge that moves the FSM (one cycle after the deciding byte).
   assign done      = (state == DONE);
   assign error     = (state == ERROR);
   assign cpu_reset = (state != DONE);
   assign dbgState  = state;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   always_comb begin
      nextState  = state;
      byte_ready = 1'b0;
      case (state)
         IDLE: begin
            if (start) nextState = LEN_LO;
         end
         LEN_LO: begin
            byte_ready = 1'b1;
            if (byte_valid) nextState = LEN_HI;
         end
         LEN_HI: begin
            byte_ready = 1'b1;
            if (byte_valid) nextState = lenBad ? ERROR : DATA;
         end
         DATA: begin
            byte_ready = 1'b1;
            // The last word of the image moves us on to the checksum byte.
            if (byte_valid && (lane == 2'd3) && (wordsNext == lenReg))
               nextState = CHECK;
         end
         CHECK: begin
            byte_ready = 1'b1;
            if (byte_valid) nextState = (byte_data == csum) ? DONE : ERROR;
         end
         DONE: begin
            nextState = DONE;
         end
         ERROR: begin
            if (start) nextState = LEN_LO;
         end
         default: nextState = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         mem_we       <= 1'b0;
         mem_addr     <= 32'd0;
         mem_wdata    <= '0;
         words_loaded <= 16'd0;
         csum         <= 8'd0;
         lane         <= 2'd0;
         lenReg       <= 16'd0;
         wordBuf      <= '0;
      end else begin
         mem_we <= 1'b0;

         if (startOk) begin
            words_loaded <= 16'd0;
            csum         <= 8'd0;
            lane         <= 2'd0;
         end

         if (accept) begin
            case (state)
               LEN_LO: begin
                  lenReg[7:0] <= byte_data;
                  csum        <= csum ^ byte_data;
               end
               LEN_HI: begin
                  lenReg[15:8] <= byte_data;
                  csum         <= csum ^ byte_data;
               end
               DATA: begin
                  csum <= csum ^ byte_data;
                  lane <= lane + 2'd1;
                  case (lane)
                     2'd0: wordBuf[7:0]   <= byte_data;
                     2'd1: wordBuf[15:8]  <= byte_data;
                     2'd2: wordBuf[23:16] <= byte_data;
                     default: begin
                        // Fourth byte completes the word: write it straight
                        // from the incoming byte plus the buffered lanes.
                        mem_we       <= 1'b1;
                        mem_addr     <= {14'd0, words_loaded, 2'b00};
                        mem_wdata    <= {byte_data, wordBuf};
                        words_loaded <= wordsNext;
                     end
                  endcase
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;

   localparam int DEPTH = 300;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        byte_valid;
   logic [7:0]  byte_data;
   logic        byte_ready;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [15:0] words_loaded;
   logic        cpu_reset;
   logic        done;
   logic        error;
   logic [2:0]  dbgState;

   int checks = 0;
   int errors = 0;

   // Scoreboard: {address, word} of every write the image should produce.
   logic [63:0] expQ[$];
   // Byte stream of the image currently being sent.
   logic [7:0]  img[$];

   program_loader #(.MEMORY_DEPTH(DEPTH), .DATA_WIDTH(32)) dut (
      .clk(clk), .reset(reset), .start(start),
      .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .words_loaded(words_loaded), .cpu_reset(cpu_reset),
      .done(done), .error(error), .dbgState(dbgState)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- checker ----------------
   task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   // Write monitor: every strobe must match the next expected write.
   always @(negedge clk) begin
      if (!reset && mem_we) begin
         if (expQ.size() == 0) begin
            checkVal("unexpected_write", 32'd1, 32'd0);
         end else begin
            logic [63:0] e;
            e = expQ.pop_front();
            checkVal("wr_addr", mem_addr, e[63:32]);
            checkVal("wr_data", mem_wdata, e[31:0]);
         end
      end
   end

   // ---------------- drivers ----------------
   task automatic doReset();
      reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
   endtask

   task automatic pulseStart();
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic sendByte(input logic [7:0] b);
      int waitCnt;
      waitCnt    = 0;
      byte_valid = 1'b1;
      byte_data  = b;
      @(negedge clk);
      while (!byte_ready && waitCnt < 50) begin
         @(negedge clk);
         waitCnt++;
      end
      if (!byte_ready) begin
         checkVal("ready_timeout", 32'd0, 32'd1);
         byte_valid = 1'b0;
      end else begin
         @(posedge clk);
         #1 byte_valid = 1'b0;
      end
   endtask

   // Image builder: header N, 4N random payload bytes, XOR checksum
   // (optionally corrupted by a non-zero flip).
   task automatic buildImage(input int n, input bit corrupt);
      logic [7:0] c;
      img.delete();
      img.push_back(n[7:0]);
      img.push_back(n[15:8]);
      for (int i = 0; i < 4 * n; i++) img.push_back(8'($urandom_range(0, 255)));
      c = 8'd0;
      foreach (img[i]) c ^= img[i];
      if (corrupt) c ^= 8'($urandom_range(1, 255));
      img.push_back(c);
   endtask

   // Sends img and checks the outcome predicted from the image contents.
   task automatic runImage(input bit doStart, input int gapMin, input int gapMax);
      int         n;
      bit         badLen;
      bit         lane3;
      bit         expDone;
      logic [7:0] x;
      logic [31:0] w;
      n      = int'({img[1], img[0]});
      badLen = (n == 0) || (n > DEPTH);
      x = 8'd0;
      for (int i = 0; i < img.size() - 1; i++) x ^= img[i];
      expDone = !badLen && (img.size() == 4 * n + 3) && (img[img.size() - 1] == x);

      if (doStart) begin
         pulseStart();
         checkVal("err_clr_on_start", 32'(error), 32'd0);
         checkVal("cnt_clr_on_start", 32'(words_loaded), 32'd0);
      end

      for (int i = 0; i < img.size(); i++) begin
         lane3 = (i >= 2) && (i < 2 + 4 * n) && ((i - 2) % 4 == 3);
         if (lane3) begin
            w = {img[i], img[i-1], img[i-2], img[i-3]};
            expQ.push_back({32'(4 * ((i - 2) / 4)), w});
         end
         sendByte(img[i]);
         if (lane3) begin
            #2 checkVal("we_after_lane3", 32'(mem_we), 32'd1);
         end
         if (i < img.size() - 1) begin
            repeat ($urandom_range(gapMin, gapMax)) begin
               @(posedge clk);
               #1;
            end
         end
      end

      #2;
      checkVal("done", 32'(done), 32'(expDone));
      checkVal("error", 32'(error), 32'(!expDone));
      checkVal("cpu_reset", 32'(cpu_reset), 32'(!expDone));
      checkVal("words_loaded", 32'(words_loaded), badLen ? 32'd0 : 32'(n));
      checkVal("ready_after_end", 32'(byte_ready), 32'd0);
      checkVal("writes_pending", 32'(expQ.size()), 32'd0);
   endtask

   task automatic loadTest2Image();
      img = '{8'h01, 8'h00, 8'h20, 8'h08, 8'h00, 8'h05, 8'h2C};
   endtask

   // ---------------- stimulus ----------------
   initial begin
      reset      = 1'b1;
      start      = 1'b0;
      byte_valid = 1'b0;
      byte_data  = 8'h00;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;

      // Reset values
      checkVal("rst_mem_we", 32'(mem_we), 32'd0);
      checkVal("rst_mem_addr", mem_addr, 32'd0);
      checkVal("rst_mem_wdata", mem_wdata, 32'd0);
      checkVal("rst_words", 32'(words_loaded), 32'd0);
      checkVal("rst_cpu_reset", 32'(cpu_reset), 32'd1);
      checkVal("rst_done", 32'(done), 32'd0);
      checkVal("rst_error", 32'(error), 32'd0);
      checkVal("rst_ready", 32'(byte_ready), 32'd0);

      // Byte offered in IDLE is ignored
      byte_valid = 1'b1;
      byte_data  = 8'hAA;
      repeat (3) begin
         @(negedge clk);
         checkVal("idle_ready", 32'(byte_ready), 32'd0);
      end
      // start with a byte in the same cycle: only start acts
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      byte_valid = 1'b0;
      checkVal("start_to_len_lo", 32'(byte_ready), 32'd1);
      checkVal("start_words", 32'(words_loaded), 32'd0);

      // Single-word image, back-to-back
      loadTest2Image();
      runImage(1'b0, 0, 0);

      // start ignored in DONE
      pulseStart();
      checkVal("done_start_ignored", 32'(done), 32'd1);
      checkVal("done_no_ready", 32'(byte_ready), 32'd0);

      // Two-word image, one idle cycle between bytes
      doReset();
      img = '{8'h02, 8'h00, 8'h05, 8'h00, 8'h08, 8'h20, 8'h20, 8'h40, 8'h09, 8'h01, 8'h00};
      x_fix_checksum();
      runImage(1'b1, 1, 1);

      // Bad checksum then retry from ERROR
      doReset();
      loadTest2Image();
      img[6] = 8'h2D;
      runImage(1'b1, 0, 0);
      loadTest2Image();
      runImage(1'b1, 0, 0);

      // Length out of range, then zero length
      doReset();
      img = '{8'h2D, 8'h01};
      runImage(1'b1, 0, 0);
      byte_valid = 1'b1;
      byte_data  = 8'h55;
      repeat (3) begin
         @(negedge clk);
         checkVal("err_no_accept", 32'(byte_ready), 32'd0);
      end
      byte_valid = 1'b0;
      img = '{8'h00, 8'h00};
      runImage(1'b1, 0, 0);

      // Reset in the middle of the payload
      doReset();
      pulseStart();
      sendByte(8'h01);
      sendByte(8'h00);
      sendByte(8'h20);
      sendByte(8'h08);
      doReset();
      checkVal("midrst_ready", 32'(byte_ready), 32'd0);
      checkVal("midrst_we", 32'(mem_we), 32'd0);
      checkVal("midrst_cpu_reset", 32'(cpu_reset), 32'd1);
      checkVal("midrst_words", 32'(words_loaded), 32'd0);
      loadTest2Image();
      runImage(1'b1, 0, 0);

      // Largest accepted image
      doReset();
      buildImage(DEPTH, 1'b0);
      runImage(1'b1, 0, 0);

      // Randomized images
      for (int k = 0; k < 8; k++) begin
         doReset();
         buildImage($urandom_range(1, 6), ($urandom_range(0, 2) == 0));
         runImage(1'b1, 0, 3);
      end

      repeat (3) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Replaces the last byte of img with the XOR of all the others.
   task automatic x_fix_checksum();
      logic [7:0] c;
      c = 8'd0;
      for (int i = 0; i < img.size() - 1; i++) c ^= img[i];
      img[img.size() - 1] = c;
   endtask

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Boot-time loader upstream of the MIPS single-cycle core's program memory.
- Receives a byte stream (valid/ready) carrying a length header, a payload and a checksum.
- Assembles the payload into 32-bit instruction words and writes them sequentially into program memory from byte address 0.
- Holds the processor in reset until a verified image is loaded; then releases it.

Parameters:
MEMORY_DEPTH, 300, program memory capacity in 32-bit words; maximum accepted word count.
DATA_WIDTH, 32, instruction word width (fixed at 32; 4 bytes per word).

Ports:
clk  input  1  single clock; all state changes on the rising edge.
reset  input  1  synchronous, active-high reset.
start  input  1  one-cycle request to begin a load; honoured only in IDLE or ERROR.
byte_valid  input  1  byte_data holds a valid byte.
byte_data  input  8  stream byte.
byte_ready  output  1  loader accepts a byte this cycle.
mem_we  output  1  program memory write strobe, one cycle per word.
mem_addr  output  32  byte address of the word being written (multiple of 4).
mem_wdata  output  32  instruction word being written.
words_loaded  output  16  count of words written in the current load.
cpu_reset  output  1  processor reset hold; high until a successful load completes.
done  output  1  load completed and checksum matched.
error  output  1  load aborted (bad length or bad checksum).

Behaviour:
- Handshake
  - A byte is accepted on an edge where byte_valid & byte_ready = 1.
  - byte_ready is decoded from state: 1 in LEN_LO, LEN_HI, DATA and CHECK; 0 otherwise.
  - byte_valid while byte_ready = 0 is ignored, with no state change.
- Reset (synchronous, next edge)
  - state = IDLE; byte_ready = 0; mem_we = 0; mem_addr = 0; mem_wdata = 0; words_loaded = 0.
  - cpu_reset = 1; done = 0; error = 0; checksum accumulator = 0; byte lane = 0.
  - A reset mid-load discards the partial word with no write. Words already written stay in memory.
- States
  - IDLE: start -> LEN_LO. Clears words_loaded, checksum and byte lane.
  - LEN_LO: accepted byte -> N[7:0]; go to LEN_HI.
  - LEN_HI: accepted byte -> N[15:8]. If the resulting N = 0 or N > MEMORY_DEPTH -> ERROR; else -> DATA.
  - DATA: bytes are packed little-endian (lane 0 -> [7:0] ... lane 3 -> [31:24]).
    - On the edge that accepts lane 3: mem_we <= 1, mem_addr <= 4*words_loaded, mem_wdata <= assembled word, words_loaded <= words_loaded+1.
    - The write is therefore visible 1 cycle after the 4th byte is accepted.
    - mem_we returns to 0 on the following edge.
    - When the incremented count equals N -> CHECK.
  - CHECK: the accepted byte is compared with the XOR of every previously accepted byte (both length bytes plus all payload bytes). Equal -> DONE; else -> ERROR.
  - DONE: done = 1, cpu_reset = 0, both registered, so they are visible the cycle after the checksum byte is accepted. DONE is terminal until reset; start is ignored.
  - ERROR: error = 1, cpu_reset = 1, done = 0. start -> LEN_LO, clearing error, words_loaded, checksum and byte lane on that edge. mem_addr restarts at 0.
- start asserted in LEN_LO/LEN_HI/DATA/CHECK/DONE has no effect.
- start and a byte in the same cycle in IDLE: only start is acted on (byte_ready = 0).
- mem_addr and mem_wdata hold their last written values between writes.
- words_loaded never exceeds N. Bytes offered after DONE/ERROR are not accepted.

Test Plan:
1. Reset -> all outputs at their reset values, including cpu_reset = 1. byte_valid = 1 with byte 0xAA in IDLE -> byte_ready = 0 and no state change.
2. start; bytes 01 00 20 08 00 05 2C, back-to-back -> mem_we high for exactly one cycle with mem_addr = 0x0, mem_wdata = 0x05000820; done = 1 and cpu_reset = 0 one cycle after byte 2C is accepted; words_loaded = 1.
3. start; N = 2 with byte_valid gapped every other cycle; words 0x20080005, 0x01094020; correct checksum -> two writes at 0x0 and 0x4 with those words; done = 1; words_loaded = 2.
4. Image from (2) with checksum byte 0x2D -> error = 1, cpu_reset stays 1, done = 0. Then start and resend the correct image -> error clears on the start edge; write at 0x0; done = 1.
5. Length bytes 2D 01 (N = 301) -> ERROR on the edge after the second length byte; mem_we never asserts. Length 00 00 -> same response.
6. reset asserted after 2 payload bytes of a load -> IDLE, no mem_we. A following start and full image from (2) -> the write lands at address 0x0.
